mux_2_1_arb: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared `mux_2_1` datapath. Two agents each request ownership of the shared 2:1 mux. The block grants one owner at a time, drives the mux `sel`, and registers the selected data onto a single output with a valid flag. It sits between the requesting agents and the downstream consumer of `y`.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/mux_2_1.sv | 15 +
 rtl/mux_2_1_arb.sv | 138 +++++++++++++
 tb/tb_mux_2_1_arb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the mux_2_1_arb arbiter.
//   state_e  : arbiter FSM state (IDLE/OWN0/OWN1, 2-bit encoding)
//   LAST_RST : reset value of the round-robin pointer (1 -> agent 0 wins first tie)
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/mux_2_1.sv
// mux_2_1: 1-bit 2:1 multiplexer cell.
//   a   : input selected when sel=0
//   b   : input selected when sel=1
//   sel : select
//   y   : output
module mux_2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_2_1_arb.sv
// mux_2_1_arb: two-requester round-robin arbiter driving a shared 2:1 mux,
// with a registered data output.
//   clk, rst     : clock, synchronous active-high reset
//   req0, req1   : ownership requests from agent 0 / agent 1
//   d0, d1       : data from agent 0 / agent 1 (DATA_W bits)
//   gnt0, gnt1   : current owner (one-hot or zero)
//   sel          : mux select (0 -> d0, 1 -> d1), holds its value in IDLE
//   y, y_valid   : registered mux output and its valid flag
//   busy         : gnt0 | gnt1
// Optional feature: define MUX_ARB_HOLD_LIMIT_EN to preempt an owner after
// MAX_HOLD consecutive cycles while the other agent waits.
module mux_2_1_arb
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] y_q;
  logic              y_valid_q;
  logic [DATA_W-1:0] mux_y;
  logic              other_req;
  logic              hold_expire;

  // Request of the agent that is not the current owner.
  assign other_req = (state_q == OWN1) ? req0 : req1;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Preempt on the edge where the count would reach MAX_HOLD, so the owner
  // keeps the grant for exactly MAX_HOLD cycles while the other agent waits.
  assign hold_expire = (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && other_req && (cnt_q != CNT_W'(MAX_HOLD))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign hold_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0 || (req1 && hold_expire)) state_d = req1 ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!req1 || (req0 && hold_expire)) state_d = req0 ? OWN0 : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == OWN0) && (state_q != OWN0)) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if ((state_d == OWN1) && (state_q != OWN1)) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux_2_1 u_mux (
      .a   (d0[i]),
      .b   (d1[i]),
      .sel (sel_q),
      .y   (mux_y[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (state_q != IDLE) begin
      y_q       <= mux_y;
      y_valid_q <= 1'b1;
    end else begin
      y_valid_q <= 1'b0;
    end
  end

  assign gnt0    = (state_q == OWN0);
  assign gnt1    = (state_q == OWN1);
  assign busy    = gnt0 | gnt1;
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_2_1_arb.sv
module tb_mux_2_1_arb;

  localparam int unsigned DW = 8;
  localparam int MH = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          gnt0, gnt1, sel, y_valid, busy;
  logic [DW-1:0] y;

  mux_2_1_arb #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .d0      (d0),
    .d1      (d1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];

  // Reference model: owner (-1 none, 0, 1), round-robin pointer, hold count.
  int m_own   = -1;
  int m_last  = 1;
  int m_hold  = 0;
  int m_sel   = 0;
  int m_valid = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit a, input bit b,
                      input logic [DW-1:0] x0, input logic [DW-1:0] x1);
    bit rq[2];
    logic [DW-1:0] dd[2];
    int nxt, mine, oth;
    @(negedge clk);
    rst = r; req0 = a; req1 = b; d0 = x0; d1 = x1;
    rq[0] = a; rq[1] = b; dd[0] = x0; dd[1] = x1;
    if (r) begin
      m_own = -1; m_last = 1; m_hold = 0; m_sel = 0; m_valid = 0;
    end else begin
      m_valid = (m_own != -1);
      if (m_own != -1) exp_q.push_back(dd[m_own]);
      oth = 0;
      if (m_own == -1) begin
        if (a && b)  nxt = 1 - m_last;
        else if (a)  nxt = 0;
        else if (b)  nxt = 1;
        else         nxt = -1;
      end else begin
        mine = rq[m_own];
        oth  = rq[1 - m_own];
        if (!mine)                                      nxt = oth ? 1 - m_own : -1;
        else if (HOLD_EN && oth && m_hold == MH - 1)    nxt = 1 - m_own;
        else                                            nxt = m_own;
      end
      if (nxt != m_own)                                 m_hold = 0;
      else if (m_own != -1 && oth != 0 && m_hold < MH)  m_hold++;
      if (nxt != -1 && nxt != m_own) begin
        m_last = nxt;
        m_sel  = nxt;
      end
      m_own = nxt;
    end
    @(posedge clk);
    #1;
    chk("gnt0",    int'(gnt0),    int'(m_own == 0));
    chk("gnt1",    int'(gnt1),    int'(m_own == 1));
    chk("busy",    int'(busy),    int'(m_own != -1));
    chk("sel",     int'(sel),     m_sel);
    chk("y_valid", int'(y_valid), m_valid);
  endtask

  // Monitor: every cycle the DUT shows valid data, compare against the scoreboard.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (y_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL y_unexpected: got %0h with no expected entry", y);
        end else begin
          e = exp_q.pop_front();
          chk("y", int'(y), int'(e));
        end
      end
    end
  end

  initial begin
    bit a, b;
    // Reset, then single requester agent 0 with A5.
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00);
    chk("y_rst", int'(y), 0);
    repeat (3) step(0, 1, 0, 8'hA5, 8'h5A);
    step(0, 0, 0, 8'hA5, 8'h5A);
    step(0, 0, 0, 8'hA5, 8'h5A);
    chk("y_hold_idle", int'(y), 8'hA5);

    // Tie from reset, then handover without an IDLE bubble.
    step(1, 0, 0, 8'h11, 8'h22);
    step(0, 1, 1, 8'h11, 8'h22);
    step(0, 1, 1, 8'h11, 8'h22);
    step(0, 0, 1, 8'h11, 8'h22);
    step(0, 0, 1, 8'h11, 8'h22);
    step(0, 0, 0, 8'h11, 8'h22);
    step(0, 0, 0, 8'h11, 8'h22);

    // Alternating ties through IDLE.
    step(1, 0, 0, 8'h00, 8'h00);
    for (int unsigned i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'(8'h30 + i), 8'(8'h40 + i));
      step(0, 0, 0, 8'h00, 8'h00);
      step(0, 0, 0, 8'h00, 8'h00);
    end

    // Both held high for a long stretch (hold limit or indefinite ownership).
    for (int unsigned i = 0; i < 20; i++) step(0, 1, 1, 8'(i), 8'(8'h80 + i));
    step(0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 8'h00, 8'h00);

    // Reset while agent 1 owns, then tie after reset.
    step(0, 0, 1, 8'h01, 8'h02);
    step(0, 0, 1, 8'h01, 8'h02);
    step(1, 1, 1, 8'h01, 8'h02);
    chk("y_after_rst", int'(y), 0);
    step(0, 1, 1, 8'h03, 8'h04);
    step(0, 1, 1, 8'h03, 8'h04);
    step(0, 0, 0, 8'h03, 8'h04);
    step(0, 0, 0, 8'h03, 8'h04);

    // Single requester agent 1 toggling 1,0,1.
    step(0, 0, 1, 8'h00, 8'h77);
    step(0, 0, 1, 8'h00, 8'h78);
    step(0, 0, 0, 8'h00, 8'h79);
    step(0, 0, 1, 8'h00, 8'h7A);
    step(0, 0, 1, 8'h00, 8'h7B);
    step(0, 0, 0, 8'h00, 8'h7C);
    step(0, 0, 0, 8'h00, 8'h7C);

    // Random traffic with sticky requests and occasional reset.
    a = 0; b = 0;
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(($urandom_range(0, 49) == 0), a, b, 8'($urandom), 8'($urandom));
    end
    step(0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
